// File: rtl/ps2_kbd_rx_ctrl.sv
// PS/2 keyboard receive controller: pin synchronizers, 11-bit frame
// sequencer with inactivity timeout, scan-code FIFO with valid/pop drain
// and sticky frame/parity/overflow flags.
// Optional build macro: PS2_PARITY_CHECK_EN enables odd-parity checking
// (parity_err is tied low when it is not defined).
module ps2_kbd_rx_ctrl #(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ps2_clk,
    input  logic                        ps2_data,
    output logic                        code_valid,
    output logic [7:0]                  code_data,
    input  logic                        code_pop,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        frame_err,
    output logic                        parity_err,
    output logic                        overflow,
    input  logic                        err_clr
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_e;

    // synchronizer / edge-detect stage
    logic clk_s1_q, clk_s2_q, clk_prev_q;
    logic dat_s1_q, dat_s2_q;
    logic fall_q, bit_q;

    // frame sequencer
    state_e         state_q, state_d;
    logic [7:0]     shift_q, shift_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           push_c;
    logic           frame_set_c;
    logic           parity_ok_c;

    // FIFO
    logic [7:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           code_valid_q, code_valid_d;
    logic [7:0]     code_data_q, code_data_d;
    logic           pop_en_c, full_c, wr_en_c, ovf_set_c;

    // sticky flags
    logic           frame_err_q, frame_err_d;
    logic           overflow_q, overflow_d;

`ifdef PS2_PARITY_CHECK_EN
    logic           par_q, par_d;
    logic           parity_set_c;
    logic           parity_err_q, parity_err_d;
`endif

    // Two-stage synchronizers plus registered falling-edge pulse and aligned data bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            fall_q     <= 1'b0;
            bit_q      <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= ps2_data;
            dat_s2_q   <= dat_s1_q;
            fall_q     <= clk_prev_q & ~clk_s2_q;
            bit_q      <= dat_s2_q;
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    assign parity_ok_c = ^{shift_q, par_q};
`else
    assign parity_ok_c = 1'b1;
`endif

    // Frame sequencer next state, timeout counter and event pulses
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        tmo_d       = (state_q == IDLE) ? '0 : tmo_q + TW'(1);
        push_c      = 1'b0;
        frame_set_c = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        par_d        = par_q;
        parity_set_c = 1'b0;
`endif
        if (fall_q) begin
            tmo_d = '0;
            case (state_q)
                IDLE: begin
                    if (!bit_q) begin
                        state_d   = DATA;
                        shift_d   = '0;
                        bit_cnt_d = '0;
                    end else begin
                        frame_set_c = 1'b1;
                    end
                end
                DATA: begin
                    shift_d   = {bit_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    par_d = bit_q;
`endif
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!bit_q) begin
                        frame_set_c = 1'b1;
                    end else if (parity_ok_c) begin
                        push_c = 1'b1;
                    end else begin
`ifdef PS2_PARITY_CHECK_EN
                        parity_set_c = 1'b1;
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if ((state_q != IDLE) && (tmo_q == TW'(TIMEOUT_CYCLES - 1))) begin
            // inactivity inside a frame: abandon the partial byte
            frame_set_c = 1'b1;
            state_d     = IDLE;
            tmo_d       = '0;
        end
    end

    // FIFO pointer/count update and registered head entry
    always_comb begin
        pop_en_c  = code_pop && (count_q != '0);
        full_c    = (count_q == CW'(FIFO_DEPTH));
        wr_en_c   = push_c && (!full_c || pop_en_c);
        ovf_set_c = push_c && full_c && !pop_en_c;

        wr_ptr_d = wr_en_c  ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_en_c ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(wr_en_c) - CW'(pop_en_c);

        code_valid_d = (count_d != '0);
        if (wr_en_c && (wr_ptr_q == rd_ptr_d)) begin
            code_data_d = shift_q;
        end else begin
            code_data_d = mem_q[rd_ptr_d];
        end

        frame_err_d = (frame_err_q & ~err_clr) | frame_set_c;
        overflow_d  = (overflow_q  & ~err_clr) | ovf_set_c;
`ifdef PS2_PARITY_CHECK_EN
        parity_err_d = (parity_err_q & ~err_clr) | parity_set_c;
`endif
    end

    // State, FIFO control and flag registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            tmo_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            code_valid_q <= 1'b0;
            code_data_q  <= '0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            tmo_q        <= tmo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            code_valid_q <= code_valid_d;
            code_data_q  <= code_data_d;
            frame_err_q  <= frame_err_d;
            overflow_q   <= overflow_d;
`ifdef PS2_PARITY_CHECK_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // FIFO storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_c) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign code_valid = code_valid_q;
    assign code_data  = code_data_q;
    assign fifo_count = count_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;
`ifdef PS2_PARITY_CHECK_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_kbd_rx_ctrl.sv
// Directed bench for ps2_kbd_rx_ctrl: FIFO_DEPTH=8, TIMEOUT_CYCLES=200,
// PS/2 bit period 40 clk (20 low / 20 high). Honours PS2_PARITY_CHECK_EN.
module tb_ps2_kbd_rx_ctrl;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TMO   = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       code_valid;
    logic [7:0] code_data;
    logic       code_pop = 1'b0;
    logic [3:0] fifo_count;
    logic       frame_err;
    logic       parity_err;
    logic       overflow;
    logic       err_clr = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    // code_valid seen 3 and 4 cycles after the last stop-bit pin fall
    logic v_at3, v_at4;

    ps2_kbd_rx_ctrl #(
        .FIFO_DEPTH    (DEPTH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .code_valid(code_valid),
        .code_data (code_data),
        .code_pop  (code_pop),
        .fifo_count(fifo_count),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .overflow  (overflow),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, got running, need finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic v);
        ps2_data = v;
        tick(10);
        ps2_clk = 1'b0;
        tick(20);
        ps2_clk = 1'b1;
        tick(10);
    endtask

    // full frame; optional pop pulse in the FIFO-write cycle of the stop bit
    task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                              input logic pop_at_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_data = stp;
        tick(10);
        ps2_clk = 1'b0;
        tick(3);
        v_at3 = code_valid;
        code_pop = pop_at_stop;
        tick(1);
        code_pop = 1'b0;
        v_at4 = code_valid;
        tick(16);
        ps2_clk = 1'b1;
        tick(10);
    endtask

    task automatic send_good(input logic [7:0] b);
        send_frame(b, ~^b, 1'b1, 1'b0);
    endtask

    task automatic pop1;
        code_pop = 1'b1;
        tick(1);
        code_pop = 1'b0;
    endtask

    task automatic clr1;
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_b;

        // reset values
        tick(4);
        rst = 1'b1;
        tick(4);
        chk("rst_valid", 16'(code_valid), 16'h0);
        chk("rst_data", 16'(code_data), 16'h00);
        chk("rst_count", 16'(fifo_count), 16'h0);
        chk("rst_frame_err", 16'(frame_err), 16'h0);
        chk("rst_parity_err", 16'(parity_err), 16'h0);
        chk("rst_overflow", 16'(overflow), 16'h0);

        // single good frame 0x1C, parity 0
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        chk("t1_valid_at3", 16'(v_at3), 16'h0);
        chk("t1_valid_at4", 16'(v_at4), 16'h1);
        chk("t1_data", 16'(code_data), 16'h1C);
        chk("t1_count", 16'(fifo_count), 16'h1);
        chk("t1_frame_err", 16'(frame_err), 16'h0);
        chk("t1_parity_err", 16'(parity_err), 16'h0);
        chk("t1_overflow", 16'(overflow), 16'h0);
        pop1();
        chk("t1_pop_valid", 16'(code_valid), 16'h0);
        chk("t1_pop_count", 16'(fifo_count), 16'h0);
        pop1();
        chk("t1_empty_pop_count", 16'(fifo_count), 16'h0);

        // bad parity
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
        chk("t2_parity_err", 16'(parity_err), 16'h1);
        chk("t2_count", 16'(fifo_count), 16'h0);
        chk("t2_valid", 16'(code_valid), 16'h0);
        clr1();
        chk("t2_clr_parity_err", 16'(parity_err), 16'h0);
`else
        chk("t2_parity_err", 16'(parity_err), 16'h0);
        chk("t2_count", 16'(fifo_count), 16'h1);
        chk("t2_data", 16'(code_data), 16'h1C);
        pop1();
        chk("t2_pop_count", 16'(fifo_count), 16'h0);
`endif
        chk("t2_frame_err", 16'(frame_err), 16'h0);

        // nine frames into an 8-deep FIFO (pointers start mid-buffer -> wrap)
        for (int i = 1; i <= 9; i++) send_good(8'(i));
        chk("t3_count", 16'(fifo_count), 16'h8);
        chk("t3_overflow", 16'(overflow), 16'h1);
        for (int i = 1; i <= 8; i++) begin
            exp_b = 8'(i);
            chk($sformatf("t3_pop%0d", i), 16'(code_data), 16'(exp_b));
            pop1();
        end
        chk("t3_drained_valid", 16'(code_valid), 16'h0);
        chk("t3_drained_count", 16'(fifo_count), 16'h0);
        clr1();
        chk("t3_clr_overflow", 16'(overflow), 16'h0);

        // push while full with a simultaneous pop
        for (int i = 0; i < 8; i++) send_good(8'(8'h11 + i));
        chk("t4_full_count", 16'(fifo_count), 16'h8);
        send_frame(8'h19, ~^8'h19, 1'b1, 1'b1);
        chk("t4_overflow", 16'(overflow), 16'h0);
        chk("t4_count", 16'(fifo_count), 16'h8);
        for (int i = 0; i < 8; i++) begin
            exp_b = 8'(8'h12 + i);
            chk($sformatf("t4_pop%0d", i), 16'(code_data), 16'(exp_b));
            pop1();
        end
        chk("t4_drained_valid", 16'(code_valid), 16'h0);

        // timeout after start + 4 data bits of 0xA5
        exp_b = 8'hA5;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(exp_b[i]);
        tick(173 - 30 + 30);
        chk("t5_frame_err_200", 16'(frame_err), 16'h0);
        tick(1);
        chk("t5_frame_err_201", 16'(frame_err), 16'h1);
        chk("t5_count", 16'(fifo_count), 16'h0);
        ps2_data = 1'b1;
        tick(5);
        send_good(8'h5A);
        chk("t5_data", 16'(code_data), 16'h5A);
        chk("t5_next_count", 16'(fifo_count), 16'h1);
        chk("t5_parity_err", 16'(parity_err), 16'h0);
        clr1();
        chk("t5_clr_frame_err", 16'(frame_err), 16'h0);
        pop1();

        // bad stop bit
        send_frame(8'h33, ~^8'h33, 1'b0, 1'b0);
        chk("t6_frame_err", 16'(frame_err), 16'h1);
        chk("t6_count", 16'(fifo_count), 16'h0);
        ps2_data = 1'b1;
        clr1();

        // reset mid-frame on a full, overflowed FIFO
        for (int i = 0; i < 9; i++) send_good(8'(8'h21 + i));
        chk("t7_pre_overflow", 16'(overflow), 16'h1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        rst = 1'b0;
        tick(2);
        chk("t7_rst_valid", 16'(code_valid), 16'h0);
        chk("t7_rst_data", 16'(code_data), 16'h00);
        chk("t7_rst_count", 16'(fifo_count), 16'h0);
        chk("t7_rst_frame_err", 16'(frame_err), 16'h0);
        chk("t7_rst_overflow", 16'(overflow), 16'h0);
        ps2_data = 1'b1;
        rst = 1'b1;
        tick(5);
        send_good(8'hF0);
        chk("t7_data", 16'(code_data), 16'hF0);
        chk("t7_count", 16'(fifo_count), 16'h1);
        chk("t7_frame_err", 16'(frame_err), 16'h0);
        chk("t7_parity_err", 16'(parity_err), 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
